// File: rtl/program_loader_if.sv
// Program word stream into the instruction-memory loader.
// Plain valid/ready handshake; in_data/in_last held until accepted.
interface program_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/program_loader.sv
// Instruction-memory writer: streams a program in from address 0,
// optionally pads the tail with HLT, and gates the CPU via cpu_halt.
module program_loader #(
    parameter int          AW       = 5,
    parameter bit          PAD_EN   = 1'b1,
    parameter logic [31:0] PAD_WORD = 32'hFC00_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    program_loader_if.slave     in_if,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                cpu_halt,
    output logic                load_done,
    output logic                err_overflow,
    output logic [AW:0]         word_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [AW-1:0] wp;
    logic          xfer;
    logic          last_addr;

    assign xfer      = in_if.in_valid && in_if.in_ready;
    assign last_addr = (wp == {AW{1'b1}});

    // Loader FSM; every output is registered. load_done/cpu_halt
    // release one cycle after entering DONE so the final write lands
    // in memory before the CPU is allowed to fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wp             <= '0;
            in_if.in_ready <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            cpu_halt       <= 1'b1;
            load_done      <= 1'b0;
            err_overflow   <= 1'b0;
            word_count     <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state          <= LOAD;
                        wp             <= '0;
                        word_count     <= '0;
                        in_if.in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= wp;
                        mem_wdata  <= in_if.in_data;
                        word_count <= word_count + 1'b1;
                        if (in_if.in_last) begin
                            in_if.in_ready <= 1'b0;
                            if (PAD_EN && !last_addr) begin
                                state <= PAD;
                                wp    <= wp + 1'b1;
                            end else begin
                                state <= DONE;
                            end
                        end else if (last_addr) begin
                            state          <= ERR;
                            in_if.in_ready <= 1'b0;
                            err_overflow   <= 1'b1;
                        end else begin
                            wp <= wp + 1'b1;
                        end
                    end
                end
                PAD: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wp;
                    mem_wdata <= PAD_WORD;
                    if (last_addr) begin
                        state <= DONE;
                    end else begin
                        wp <= wp + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state          <= LOAD;
                        wp             <= '0;
                        word_count     <= '0;
                        in_if.in_ready <= 1'b1;
                        cpu_halt       <= 1'b1;
                        load_done      <= 1'b0;
                    end else begin
                        cpu_halt  <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                ERR: begin
                    if (start) begin
                        state          <= LOAD;
                        wp             <= '0;
                        word_count     <= '0;
                        in_if.in_ready <= 1'b1;
                        err_overflow   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: padded and unpadded loads,
// handshake gaps, exact fit, overflow, and reset during padding.
module tb_program_loader;

    localparam logic [31:0] PADW = 32'hFC00_0000;

    logic clk;
    logic rst;
    logic start;
    logic start2;

    logic        mem_we,    mem_we2;
    logic [4:0]  mem_addr,  mem_addr2;
    logic [31:0] mem_wdata, mem_wdata2;
    logic        cpu_halt,  cpu_halt2;
    logic        load_done, load_done2;
    logic        err_ovf,   err_ovf2;
    logic [5:0]  wc,        wc2;

    program_loader_if ifc ();
    program_loader_if ifc2 ();

    program_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_if        (ifc),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_halt     (cpu_halt),
        .load_done    (load_done),
        .err_overflow (err_ovf),
        .word_count   (wc)
    );

    program_loader #(.PAD_EN(1'b0)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .start        (start2),
        .in_if        (ifc2),
        .mem_we       (mem_we2),
        .mem_addr     (mem_addr2),
        .mem_wdata    (mem_wdata2),
        .cpu_halt     (cpu_halt2),
        .load_done    (load_done2),
        .err_overflow (err_ovf2),
        .word_count   (wc2)
    );

    int pass = 0;
    int total = 0;
    int cyc = 0;

    logic [31:0] words [64];
    logic [4:0]  qa [$];
    logic [31:0] qd [$];
    int          qt [$];
    int          q2n = 0;

    logic [47:0] exp_rst;
    assign exp_rst = {1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 6'd0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            qa.push_back(mem_addr);
            qd.push_back(mem_wdata);
            qt.push_back(cyc);
        end
        if (mem_we2 === 1'b1) q2n++;
    end

    function automatic logic [47:0] snap1();
        return {ifc.in_ready, mem_we, mem_addr, mem_wdata,
                cpu_halt, load_done, err_ovf, wc};
    endfunction

    function automatic logic [47:0] snap2();
        return {ifc2.in_ready, mem_we2, mem_addr2, mem_wdata2,
                cpu_halt2, load_done2, err_ovf2, wc2};
    endfunction

    // Index of the first logged write that is not (addr k, expected
    // data), or -1; first n addresses hold program words, rest pad.
    function automatic int first_bad(input int n);
        logic [31:0] e;
        for (int k = 0; k < qa.size(); k++) begin
            e = (k < n) ? words[k] : PADW;
            if (qa[k] !== 5'(k) || qd[k] !== e) return k;
        end
        return -1;
    endfunction

    function automatic int last_t();
        return (qt.size() > 0) ? qt[qt.size()-1] : -100;
    endfunction

    task automatic set_words();
        for (int i = 0; i < 64; i++) words[i] = 32'hA500_0000 | 32'(i);
    endtask

    task automatic qclear();
        qa.delete();
        qd.delete();
        qt.delete();
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gap, input bit mark,
                        output int acc);
        int  i;
        int  t;
        bit  fire;
        i = 0;
        t = 0;
        while (i < n && t < 100) begin
            ifc.in_valid = gap ? ~t[0] : 1'b1;
            ifc.in_data  = words[i];
            ifc.in_last  = mark && (i == n - 1);
            fire = ifc.in_valid && ifc.in_ready;
            @(negedge clk);
            if (fire) i++;
            t++;
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        acc = i;
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int k = 0; k < 80; k++) begin
            if (load_done === 1'b1) begin
                d = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        ifc.in_last = 1'b0;
        ifc2.in_valid = 1'b0;
        ifc2.in_data = '0;
        ifc2.in_last = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (snap1() !== exp_rst)
            $display("FAIL reset_dut1: got %h want %h", snap1(), exp_rst);
        else pass++;
        total++;
        if (snap2() !== exp_rst)
            $display("FAIL reset_dut2: got %h want %h", snap2(), exp_rst);
        else pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ifc.in_ready, cpu_halt, mem_we} !== 3'b010)
            $display("FAIL idle_hold: got %b want 010",
                     {ifc.in_ready, cpu_halt, mem_we});
        else pass++;
    endtask

    task automatic test_pad_load();
        int acc;
        int s;
        int d;
        set_words();
        words[0] = 32'h2001_000A;
        words[1] = 32'h2002_0014;
        words[2] = 32'h0022_1800;
        qclear();
        start_pulse();
        s = cyc;
        feed(3, 1'b0, 1'b1, acc);
        wait_done(d);
        total++;
        if (qa.size() !== 32)
            $display("FAIL pad_nwr: got %0d want 32", qa.size());
        else pass++;
        total++;
        if (first_bad(3) !== -1)
            $display("FAIL pad_seq: bad index %0d want -1", first_bad(3));
        else pass++;
        total++;
        if (qt.size() == 0 || qt[0] !== s + 1)
            $display("FAIL pad_lat: first write cyc %0d want %0d",
                     (qt.size() > 0) ? qt[0] : -1, s + 1);
        else pass++;
        total++;
        if (last_t() - qt[0] !== 31)
            $display("FAIL pad_burst: span %0d want 31", last_t() - qt[0]);
        else pass++;
        total++;
        if (d !== last_t() + 1)
            $display("FAIL pad_done: done cyc %0d want %0d", d, last_t() + 1);
        else pass++;
        total++;
        if ({wc, cpu_halt, ifc.in_ready, err_ovf} !== {6'd3, 3'b000})
            $display("FAIL pad_stat: got wc=%0d halt=%b rdy=%b err=%b want 3 0 0 0",
                     wc, cpu_halt, ifc.in_ready, err_ovf);
        else pass++;
    endtask

    task automatic test_toggle();
        int acc;
        int d;
        qclear();
        start_pulse();
        total++;
        if ({cpu_halt, load_done, ifc.in_ready} !== 3'b101)
            $display("FAIL restart_halt: got %b want 101",
                     {cpu_halt, load_done, ifc.in_ready});
        else pass++;
        feed(3, 1'b1, 1'b1, acc);
        wait_done(d);
        total++;
        if (qa.size() !== 32 || first_bad(3) !== -1)
            $display("FAIL toggle_seq: nwr %0d bad %0d want 32 -1",
                     qa.size(), first_bad(3));
        else pass++;
        total++;
        if (wc !== 6'd3 || d < 0)
            $display("FAIL toggle_wc: got wc=%0d done=%0d want 3", wc, d);
        else pass++;
    endtask

    task automatic test_exact_fit();
        int acc;
        int d;
        set_words();
        qclear();
        start_pulse();
        feed(32, 1'b0, 1'b1, acc);
        wait_done(d);
        total++;
        if (qa.size() !== 32 || first_bad(32) !== -1)
            $display("FAIL fit_seq: nwr %0d bad %0d want 32 -1",
                     qa.size(), first_bad(32));
        else pass++;
        total++;
        if (d !== last_t() + 1)
            $display("FAIL fit_done: done cyc %0d want %0d", d, last_t() + 1);
        else pass++;
        total++;
        if (wc !== 6'd32)
            $display("FAIL fit_wc: got %0d want 32", wc);
        else pass++;
    endtask

    task automatic test_overflow();
        int acc;
        int d;
        set_words();
        qclear();
        start_pulse();
        feed(33, 1'b0, 1'b0, acc);
        total++;
        if (acc !== 32)
            $display("FAIL ovf_acc: got %0d want 32", acc);
        else pass++;
        total++;
        if (qa.size() !== 32 || first_bad(32) !== -1)
            $display("FAIL ovf_seq: nwr %0d bad %0d want 32 -1",
                     qa.size(), first_bad(32));
        else pass++;
        total++;
        if ({err_ovf, ifc.in_ready, cpu_halt, load_done, wc} !== {4'b1010, 6'd32})
            $display("FAIL ovf_stat: got err=%b rdy=%b halt=%b done=%b wc=%0d want 1 0 1 0 32",
                     err_ovf, ifc.in_ready, cpu_halt, load_done, wc);
        else pass++;
        qclear();
        words[0] = 32'h1234_5678;
        start_pulse();
        total++;
        if ({err_ovf, ifc.in_ready} !== 2'b01)
            $display("FAIL ovf_clear: got err=%b rdy=%b want 0 1",
                     err_ovf, ifc.in_ready);
        else pass++;
        feed(1, 1'b0, 1'b1, acc);
        wait_done(d);
        total++;
        if (qa.size() !== 32 || first_bad(1) !== -1)
            $display("FAIL single_seq: nwr %0d bad %0d want 32 -1",
                     qa.size(), first_bad(1));
        else pass++;
        total++;
        if (wc !== 6'd1 || d < 0)
            $display("FAIL single_wc: got wc=%0d done=%0d want 1", wc, d);
        else pass++;
    endtask

    task automatic test_rst_pad();
        int acc;
        int d;
        bit found;
        set_words();
        qclear();
        start_pulse();
        feed(2, 1'b0, 1'b1, acc);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mem_we === 1'b1 && mem_addr === 5'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found)
            $display("FAIL rst_pad_reach: got no write at 10 want one");
        else pass++;
        rst = 1'b1;
        #1;
        total++;
        if (snap1() !== exp_rst)
            $display("FAIL rst_async: got %h want %h", snap1(), exp_rst);
        else pass++;
        qclear();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (qa.size() !== 0 || load_done !== 1'b0)
            $display("FAIL rst_quiet: got nwr %0d done %b want 0 0",
                     qa.size(), load_done);
        else pass++;
        start_pulse();
        feed(3, 1'b0, 1'b1, acc);
        wait_done(d);
        total++;
        if (qa.size() !== 32 || first_bad(3) !== -1 || wc !== 6'd3)
            $display("FAIL rst_reload: nwr %0d bad %0d wc %0d want 32 -1 3",
                     qa.size(), first_bad(3), wc);
        else pass++;
    endtask

    task automatic test_nopad();
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        ifc2.in_valid = 1'b1;
        ifc2.in_data  = 32'h0BAD_F00D;
        ifc2.in_last  = 1'b0;
        @(negedge clk);
        ifc2.in_data  = 32'h1357_9BDF;
        ifc2.in_last  = 1'b1;
        total++;
        if ({mem_we2, mem_addr2, mem_wdata2} !== {1'b1, 5'd0, 32'h0BAD_F00D})
            $display("FAIL nopad_w0: got %b %0d %h want 1 0 0bad_f00d",
                     mem_we2, mem_addr2, mem_wdata2);
        else pass++;
        @(negedge clk);
        ifc2.in_valid = 1'b0;
        ifc2.in_last  = 1'b0;
        total++;
        if ({mem_we2, mem_addr2, mem_wdata2, load_done2} !==
            {1'b1, 5'd1, 32'h1357_9BDF, 1'b0})
            $display("FAIL nopad_w1: got %b %0d %h done=%b want 1 1 13579bdf 0",
                     mem_we2, mem_addr2, mem_wdata2, load_done2);
        else pass++;
        @(negedge clk);
        total++;
        if ({mem_we2, load_done2, cpu_halt2} !== 3'b010)
            $display("FAIL nopad_done: got %b want 010",
                     {mem_we2, load_done2, cpu_halt2});
        else pass++;
        repeat (3) @(negedge clk);
        total++;
        if (q2n !== 2 || wc2 !== 6'd2)
            $display("FAIL nopad_count: got nwr %0d wc %0d want 2 2", q2n, wc2);
        else pass++;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        total++;
        if ({cpu_halt2, load_done2} !== 2'b10)
            $display("FAIL nopad_restart: got %b want 10",
                     {cpu_halt2, load_done2});
        else pass++;
    endtask

    initial begin
        test_reset();
        test_pad_load();
        test_toggle();
        test_exact_fit();
        test_overflow();
        test_rst_pad();
        test_nopad();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
